// File: rtl/keypad_scan_debounce.sv
// Keypad matrix scanner: walks active-low rows, synchronises the column senses and
// debounces press/release over consecutive scan ticks, emitting one-cycle key events.
module keypad_scan_debounce #(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 4,
  parameter int unsigned SCAN_DIV = 250000,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CODE_W   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [COLS-1:0]   keypadCol,
  output logic [ROWS-1:0]   keypadRow,
  output logic              key_valid,
  output logic              key_release,
  output logic              key_held,
  output logic [CODE_W-1:0] key_code
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    CONFIRM = 2'd2,
    HELD    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [COLS-1:0]     col_meta_q, col_s_q;
  logic [RW-1:0]       row_q, row_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [DW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       cand_q, cand_d;
  logic [ROWS-1:0]     row_drv_q, row_drv_d;
  logic                valid_q, valid_d;
  logic                release_q, release_d;
  logic                held_q, held_d;
  logic [CODE_W-1:0]   code_q, code_d;

  logic                tick_c;
  logic                hit_c;
  logic [CW-1:0]       hit_col_c;
  logic [RW-1:0]       next_row_c;
  logic                cnt_done_c;
  logic                cand_released_c;
  logic [CODE_W-1:0]   accept_code_c;

  assign keypadRow   = row_drv_q;
  assign key_valid   = valid_q;
  assign key_release = release_q;
  assign key_held    = held_q;
  assign key_code    = code_q;

  // Two-flop synchroniser; idles high so reset never looks like a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta_q <= '1;
      col_s_q    <= '1;
    end else begin
      col_meta_q <= keypadCol;
      col_s_q    <= col_meta_q;
    end
  end

  // Lowest-index pressed column on the currently driven row.
  always_comb begin
    hit_c     = 1'b0;
    hit_col_c = '0;
    for (int c = int'(COLS) - 1; c >= 0; c--) begin
      if (!col_s_q[c]) begin
        hit_c     = 1'b1;
        hit_col_c = CW'(c);
      end
    end
  end

  assign tick_c          = (presc_q == PW'(SCAN_DIV - 1));
  assign next_row_c      = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
  assign cnt_done_c      = ((32'(cnt_q) + 32'd1) == DEBOUNCE);
  assign cand_released_c = col_s_q[cand_q];
  assign accept_code_c   = CODE_W'(32'(row_q) * COLS + 32'(hit_col_c));

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    valid_d   = 1'b0;
    release_d = 1'b0;
    held_d    = held_q;
    code_d    = code_q;

    if (!enable) begin
      state_d = IDLE;
      row_d   = '0;
      presc_d = '0;
      cnt_d   = '0;
      held_d  = 1'b0;
    end else begin
      presc_d = tick_c ? '0 : presc_q + PW'(1);
      unique case (state_q)
        IDLE: begin
          state_d = SCAN;
          row_d   = '0;
          presc_d = '0;
          cnt_d   = '0;
        end

        SCAN: begin
          if (tick_c) begin
            if (hit_c) begin
              cand_d = hit_col_c;
              if (DEBOUNCE == 1) begin
                state_d = HELD;
                cnt_d   = '0;
                valid_d = 1'b1;
                held_d  = 1'b1;
                code_d  = accept_code_c;
              end else begin
                state_d = CONFIRM;
                cnt_d   = DW'(1);
              end
            end else begin
              row_d = next_row_c;
            end
          end
        end

        CONFIRM: begin
          if (tick_c) begin
            if (hit_c && (hit_col_c == cand_q)) begin
              if (cnt_done_c) begin
                state_d = HELD;
                cnt_d   = '0;
                valid_d = 1'b1;
                held_d  = 1'b1;
                code_d  = accept_code_c;
              end else begin
                cnt_d = cnt_q + DW'(1);
              end
            end else begin
              state_d = SCAN;
              cnt_d   = '0;
              row_d   = next_row_c;
            end
          end
        end

        HELD: begin
          // Only the accepted column matters; other keys are ignored while held.
          if (tick_c) begin
            if (cand_released_c) begin
              if (cnt_done_c) begin
                state_d   = SCAN;
                cnt_d     = '0;
                release_d = 1'b1;
                held_d    = 1'b0;
                row_d     = next_row_c;
              end else begin
                cnt_d = cnt_q + DW'(1);
              end
            end else begin
              cnt_d = '0;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end

    row_drv_d = (state_d == IDLE) ? '1 : ~(ROWS'(1) << row_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      presc_q   <= '0;
      cnt_q     <= '0;
      cand_q    <= '0;
      row_drv_q <= '1;
      valid_q   <= 1'b0;
      release_q <= 1'b0;
      held_q    <= 1'b0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      row_drv_q <= row_drv_d;
      valid_q   <= valid_d;
      release_q <= release_d;
      held_q    <= held_d;
      code_q    <= code_d;
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: a physical keypad model drives the columns, expected
// key events are queued by the stimulus and popped by an independent monitor.
module tb_keypad_scan_debounce;

  typedef struct packed {
    logic       rel;
    logic [3:0] code;
    logic [3:0] row;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst, enable;
  logic [3:0] keypadCol, keypadRow, key_code;
  logic       key_valid, key_release, key_held;

  logic       rst2, en2;
  logic [3:0] col2, row2, code2;
  logic       valid2, release2, held2;

  logic [15:0] pk;
  evt_t        q[$];
  evt_t        mon_evt;
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  int          last_evt_cyc = 0;
  int          c0, ctmp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  keypad_scan_debounce #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .keypadCol(keypadCol), .keypadRow(keypadRow),
    .key_valid(key_valid), .key_release(key_release), .key_held(key_held), .key_code(key_code)
  );

  keypad_scan_debounce #(.ROWS(4), .COLS(4), .SCAN_DIV(1), .DEBOUNCE(1)) dut_fast (
    .clk(clk), .rst(rst2), .enable(en2), .keypadCol(col2), .keypadRow(row2),
    .key_valid(valid2), .key_release(release2), .key_held(held2), .key_code(code2)
  );

  // Switch matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    keypadCol = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pk[r*4+c] && !keypadRow[r]) keypadCol[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic rel, input logic [3:0] code, input logic [3:0] row);
    evt_t e;
    e.rel = rel; e.code = code; e.row = row;
    q.push_back(e);
  endtask

  task automatic wait_q_empty(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d expected events still pending after %0d cycles", name, q.size(), budget);
      q.delete();
    end
  endtask

  task automatic wait_row(input logic [3:0] v, output int c);
    int n = 0;
    @(negedge clk); #1;
    while (keypadRow !== v && n < 64) begin
      @(negedge clk); #1;
      n++;
    end
    c = cyc;
    if (keypadRow !== v) begin
      checks++; fails++;
      $display("FAIL wait_row: keypadRow=%b never reached %b", keypadRow, v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Monitor: every presented event must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst && (key_valid || key_release)) begin
      last_evt_cyc = cyc;
      if (q.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_event: valid=%0b release=%0b code=%0d row=%b, expected no event",
                 key_valid, key_release, key_code, keypadRow);
      end else begin
        mon_evt = q.pop_front();
        check("event_kind", 32'({key_valid, key_release}), mon_evt.rel ? 32'd1 : 32'd2);
        check("event_code", 32'(key_code), 32'(mon_evt.code));
        check("event_row",  32'(keypadRow), 32'(mon_evt.row));
        check("event_held", 32'(key_held), 32'(!mon_evt.rel));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_row;
    rst = 1'b0; enable = 1'b0; pk = '0;
    rst2 = 1'b0; en2 = 1'b0; col2 = 4'b1011;

    // 1: reset values, then idle with enable low
    step(3);
    check("reset_outputs", 32'({keypadRow, key_valid, key_release, key_held, key_code}),
          32'({4'hF, 1'b0, 1'b0, 1'b0, 4'h0}));
    rst = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step(1);
      check("idle_outputs", 32'({keypadRow, key_held, key_code}), 32'({4'hF, 1'b0, 4'h0}));
    end

    // 2: free scan, each row held 4 cycles, wraps after row 3
    enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(1);
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      check("scan_row", 32'(keypadRow), 32'(exp_row));
    end

    // 3: stable key (2,1): accept on 3rd tick, release 3 ticks after col goes high
    wait_row(4'b1110, ctmp);
    pk[9] = 1'b1;
    push(1'b0, 4'd9, 4'b1011);
    wait_row(4'b1011, c0);
    wait_q_empty("press_9", 40);
    check("press_latency", 32'(last_evt_cyc - c0), 32'd12);
    pk[9] = 1'b0;
    push(1'b1, 4'd9, 4'b0111);
    wait_q_empty("release_9", 40);
    check("release_latency", 32'(last_evt_cyc - c0), 32'd24);

    // 4: bounce after 2 matching ticks aborts confirm, scan moves to row 3
    wait_row(4'b1110, ctmp);
    pk[9] = 1'b1;
    wait_row(4'b1011, c0);
    step(8);
    pk[9] = 1'b0;
    step(4);
    check("bounce_row", 32'(keypadRow), 32'(4'b0111));
    check("bounce_held", 32'(key_held), 32'd0);

    // 5: two keys on row 1, lowest column wins; other key ignored while held
    wait_row(4'b1110, ctmp);
    pk[4] = 1'b1; pk[7] = 1'b1;
    push(1'b0, 4'd4, 4'b1101);
    wait_q_empty("press_4", 60);
    pk[7] = 1'b0;
    step(30);
    check("held_other_release", 32'({key_held, key_code, keypadRow}), 32'({1'b1, 4'd4, 4'b1101}));
    pk[4] = 1'b0;
    push(1'b1, 4'd4, 4'b1011);
    wait_q_empty("release_4", 60);
    check("code_holds", 32'(key_code), 32'd4);

    // 6: disable while held, re-enable restarts at row 0
    wait_row(4'b1110, ctmp);
    pk[9] = 1'b1;
    push(1'b0, 4'd9, 4'b1011);
    wait_q_empty("press_9b", 60);
    enable = 1'b0;
    step(1);
    check("disable_outputs", 32'({key_held, keypadRow, key_code}), 32'({1'b0, 4'hF, 4'd9}));
    pk[9] = 1'b0;
    step(20);
    enable = 1'b1;
    step(1);
    check("reenable_row0", 32'(keypadRow), 32'(4'b1110));

    // async reset in the middle of confirm
    wait_row(4'b1110, ctmp);
    pk[9] = 1'b1;
    wait_row(4'b1011, c0);
    step(6);
    #2 rst = 1'b0;
    #1;
    check("async_reset", 32'({keypadRow, key_valid, key_release, key_held, key_code}),
          32'({4'hF, 1'b0, 1'b0, 1'b0, 4'h0}));
    pk[9] = 1'b0;
    step(1);
    rst = 1'b1;
    step(30);
    check("queue_drained", 32'(q.size()), 32'd0);

    // DEBOUNCE=1, SCAN_DIV=1: accept on the first sample, release on the first high sample
    rst2 = 1'b1;
    step(3);
    en2 = 1'b1;
    step(1);
    check("fast_scan_start", 32'({row2, valid2, held2}), 32'({4'b1110, 1'b0, 1'b0}));
    step(1);
    check("fast_accept", 32'({valid2, held2, code2, row2}), 32'({1'b1, 1'b1, 4'd2, 4'b1110}));
    step(1);
    check("fast_pulse_end", 32'({valid2, held2}), 32'({1'b0, 1'b1}));
    col2 = 4'hF;
    step(3);
    check("fast_release", 32'({release2, held2, code2, row2}), 32'({1'b1, 1'b0, 4'd2, 4'b1101}));
    step(1);
    check("fast_release_end", 32'(release2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
